// File: rtl/koa_pkg.sv
// Shared width helpers and stage control payload for the Karatsuba multiplier family.
package koa_pkg;

  // Width of each half operand after one Karatsuba split.
  function automatic int koa_half_w(input int w);
    return w / 32'sd2;
  endfunction

  // Width of a pre-added half pair (ah+al); one carry bit wider than a half.
  function automatic int koa_sum_w(input int w);
    return (w / 32'sd2) + 32'sd1;
  endfunction

  // Width of the middle product sa*sb.
  function automatic int koa_mid_w(input int w);
    return 32'sd2 * ((w / 32'sd2) + 32'sd1);
  endfunction

  // Per-stage control payload; data widths depend on the instance, so data
  // fields are declared in the module from its own localparams.
  typedef struct packed {
    logic valid;
    logic neg;
  } koa_stage_ctrl_t;

endpackage

// File: rtl/koa_split_preadd.sv
// Stage-1 combinational front end of a Karatsuba multiplier: sign handling,
// operand magnitude, half split and half pre-add. Kept standalone so a deeper
// multi-level KOA can reuse it per level.
module koa_split_preadd
  import koa_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             is_signed,
  output logic [koa_half_w(WIDTH)-1:0]     al,
  output logic [koa_half_w(WIDTH)-1:0]     ah,
  output logic [koa_half_w(WIDTH)-1:0]     bl,
  output logic [koa_half_w(WIDTH)-1:0]     bh,
  output logic [koa_sum_w(WIDTH)-1:0]      sa,
  output logic [koa_sum_w(WIDTH)-1:0]      sb,
  output logic                             neg
);

  localparam int H  = koa_half_w(WIDTH);
  localparam int SW = koa_sum_w(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ma_s;
  logic [WIDTH-1:0] mb_s;

  // Operand magnitudes; the most negative value maps to 2^(W-1) as unsigned.
  always_comb begin
    ma_s = a;
    mb_s = b;
    if (is_signed && a[WIDTH-1]) begin
      ma_s = (~a) + ONE_W;
    end else begin
      ma_s = a;
    end
    if (is_signed && b[WIDTH-1]) begin
      mb_s = (~b) + ONE_W;
    end else begin
      mb_s = b;
    end
  end

  // Result sign, half split and carry-preserving pre-add.
  always_comb begin
    neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    al  = ma_s[H-1:0];
    ah  = ma_s[WIDTH-1:H];
    bl  = mb_s[H-1:0];
    bh  = mb_s[WIDTH-1:H];
    sa  = {1'b0, ma_s[WIDTH-1:H]} + {1'b0, ma_s[H-1:0]};
    sb  = {1'b0, mb_s[WIDTH-1:H]} + {1'b0, mb_s[H-1:0]};
  end

  // sa/sb widths are SW by construction; tie the localparam to the ports.
  if (SW != H + 1) begin : g_bad_sum_w
    $error("koa_split_preadd: inconsistent sum width");
  end

endmodule

// File: rtl/koa_multiplier_pipe.sv
// Three-stage pipelined one-level Karatsuba multiplier with valid/ready
// handshake, full backpressure, signed/unsigned mode and sideband tag.
module koa_multiplier_pipe
  import koa_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int H  = koa_half_w(WIDTH);
  localparam int SW = koa_sum_w(WIDTH);
  localparam int MW = koa_mid_w(WIDTH);
  localparam int PW = 2 * H;
  localparam int OW = 2 * WIDTH;
  localparam logic [OW-1:0] ONE_OW = {{(OW-1){1'b0}}, 1'b1};

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("koa_multiplier_pipe: WIDTH must be even and >= 4");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("koa_multiplier_pipe: TAG_W must be >= 1");
  end

  // Global advance enable: the whole pipe moves unless a result is stuck.
  logic en_s;

  // Stage 1 outputs (combinational) and registers.
  logic [H-1:0]     al_s, ah_s, bl_s, bh_s;
  logic [SW-1:0]    sa_s, sb_s;
  logic             neg_s;
  koa_stage_ctrl_t  s1_ctrl_r;
  logic [H-1:0]     s1_al_r, s1_ah_r, s1_bl_r, s1_bh_r;
  logic [SW-1:0]    s1_sa_r, s1_sb_r;
  logic [TAG_W-1:0] s1_tag_r;

  // Stage 2 registers.
  koa_stage_ctrl_t  s2_ctrl_r;
  logic [PW-1:0]    s2_p_hi_r, s2_p_lo_r;
  logic [MW-1:0]    s2_p_mid_r;
  logic [TAG_W-1:0] s2_tag_r;

  // Stage 3 combine and output registers.
  logic [MW-1:0]    z1_s;
  logic [OW-1:0]    u_s;
  logic [OW-1:0]    prod_s;
  logic             out_valid_r;
  logic [OW-1:0]    out_product_r;
  logic [TAG_W-1:0] out_tag_r;

  koa_split_preadd #(
    .WIDTH (WIDTH)
  ) u_split (
    .a         (in_a),
    .b         (in_b),
    .is_signed (in_signed),
    .al        (al_s),
    .ah        (ah_s),
    .bl        (bl_s),
    .bh        (bh_s),
    .sa        (sa_s),
    .sb        (sb_s),
    .neg       (neg_s)
  );

  // Enable depends only on the output register state and out_ready.
  always_comb begin
    en_s = (~out_valid_r) | out_ready;
  end

  // Stage valid/sign bits: cleared by reset, advanced together on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctrl_r   <= '0;
      s2_ctrl_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      s1_ctrl_r.valid <= in_valid;
      s1_ctrl_r.neg   <= neg_s;
      s2_ctrl_r       <= s1_ctrl_r;
      out_valid_r     <= s2_ctrl_r.valid;
    end
  end

  // Stage 1 and 2 data: no reset needed, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en_s) begin
      s1_al_r    <= al_s;
      s1_ah_r    <= ah_s;
      s1_bl_r    <= bl_s;
      s1_bh_r    <= bh_s;
      s1_sa_r    <= sa_s;
      s1_sb_r    <= sb_s;
      s1_tag_r   <= in_tag;
      s2_p_hi_r  <= {{H{1'b0}}, s1_ah_r} * {{H{1'b0}}, s1_bh_r};
      s2_p_lo_r  <= {{H{1'b0}}, s1_al_r} * {{H{1'b0}}, s1_bl_r};
      s2_p_mid_r <= {{(MW-SW){1'b0}}, s1_sa_r} * {{(MW-SW){1'b0}}, s1_sb_r};
      s2_tag_r   <= s2_tag_r;
      s2_tag_r   <= s1_tag_r;
    end
  end

  // Karatsuba recombination and final sign; z1 never exceeds 2H+1 bits, so
  // its top bit is always zero and carrying it at MW bits changes nothing.
  always_comb begin
    z1_s = s2_p_mid_r - {2'b00, s2_p_hi_r} - {2'b00, s2_p_lo_r};
    u_s  = {s2_p_hi_r, s2_p_lo_r} + ({{(OW-MW){1'b0}}, z1_s} << H);
    if (s2_ctrl_r.neg) begin
      prod_s = (~u_s) + ONE_OW;
    end else begin
      prod_s = u_s;
    end
  end

  // Output registers: cleared on reset, loaded only with a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_product_r <= '0;
      out_tag_r     <= '0;
    end else if (en_s && s2_ctrl_r.valid) begin
      out_product_r <= prod_s;
      out_tag_r     <= s2_tag_r;
    end
  end

  // Port drive from registered state.
  always_comb begin
    in_ready    = en_s;
    out_valid   = out_valid_r;
    out_product = out_product_r;
    out_tag     = out_tag_r;
  end

endmodule

// File: tb/tb_koa_multiplier_pipe.sv
// Directed and streaming checks of koa_multiplier_pipe at WIDTH=128 plus an
// exhaustive sweep of a WIDTH=4 instance.
module tb_koa_multiplier_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [127:0] in_a, in_b;
  logic [7:0]   in_tag, out_tag;
  logic [255:0] out_product;

  logic         in_valid4, in_ready4, in_signed4, out_valid4, out_ready4;
  logic [3:0]   in_a4, in_b4;
  logic [0:0]   in_tag4, out_tag4;
  logic [7:0]   out_product4;

  koa_multiplier_pipe #(.WIDTH(128), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  koa_multiplier_pipe #(.WIDTH(4), .TAG_W(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_signed(in_signed4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_product(out_product4), .out_tag(out_tag4)
  );

  typedef struct { logic [255:0] prod; logic [7:0] tag; int acc; bit lat; } big_exp_t;
  typedef struct { logic [7:0] prod; logic tag; int acc; } small_exp_t;

  big_exp_t   qb[$];
  small_exp_t qs[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [255:0] drv_exp;
  bit           drv_lat;
  logic [7:0]   drv_exp4;
  logic [255:0] hold_p;
  logic [7:0]   hold_t;

  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b, input logic s);
    logic [255:0] ea, eb;
    ea = s ? {{128{a[127]}}, a} : {128'd0, a};
    eb = s ? {{128{b[127]}}, b} : {128'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [7:0] ref_mul4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [7:0] ea, eb;
    ea = s ? {{4{a[3]}}, a} : {4'd0, a};
    eb = s ? {{4{b[3]}}, b} : {4'd0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, score outputs, log accepts.
  task automatic cycle();
    big_exp_t   eb;
    small_exp_t es;
    @(negedge clk);
    if (rst) begin
      qb.delete();
      qs.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (qb.size() != 0) else begin
          n_fail++;
          $error("FAIL big_unexpected observed=result tag %0h expected=no result", out_tag);
        end
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("big_product", out_product, eb.prod);
          chk("big_tag", 256'(out_tag), 256'(eb.tag));
          if (eb.lat) chk("big_latency", 256'(cyc - eb.acc), 256'(3));
        end
      end
      if (out_valid4 && out_ready4) begin
        n_cmp++;
        assert (qs.size() != 0) else begin
          n_fail++;
          $error("FAIL small_unexpected observed=result %0h expected=no result", out_product4);
        end
        if (qs.size() != 0) begin
          es = qs.pop_front();
          chk("small_product", 256'(out_product4), 256'(es.prod));
          chk("small_tag", 256'(out_tag4), 256'(es.tag));
          chk("small_latency", 256'(cyc - es.acc), 256'(3));
        end
      end
      if (in_valid && in_ready) qb.push_back('{drv_exp, in_tag, cyc, drv_lat});
      if (in_valid4 && in_ready4) qs.push_back('{drv_exp4, in_tag4[0], cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_hand(input logic [127:0] a, input logic [127:0] b, input logic s,
                            input logic [7:0] t, input bit lat, input logic [255:0] exp);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    drv_exp = exp; drv_lat = lat;
  endtask

  task automatic drive(input logic [127:0] a, input logic [127:0] b, input logic s,
                       input logic [7:0] t, input bit lat);
    drive_hand(a, b, s, t, lat, ref_mul(a, b, s));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Bounded drain: every accepted op must come out within 20 cycles.
  task automatic drain(input string tag);
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    for (int i = 0; i < 20 && (qb.size() != 0 || qs.size() != 0); i++) cycle();
    chk(tag, 256'(qb.size() + qs.size()), 256'(0));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = 128'd0; in_b = 128'd0; in_signed = 1'b0; in_tag = 8'd0;
    out_ready = 1'b1;
    in_valid4 = 1'b0; in_a4 = 4'd0; in_b4 = 4'd0; in_signed4 = 1'b0; in_tag4 = 1'b0;
    out_ready4 = 1'b1;
    drv_exp = 256'd0; drv_lat = 1'b0; drv_exp4 = 8'd0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state, first cycle after reset release.
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_out_product", out_product, 256'd0);
    chk("rst_out_tag", 256'(out_tag), 256'(8'd0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_out_valid4", 256'(out_valid4), 256'(1'b0));

    // Directed vectors with hand-computed products.
    drive_hand({128{1'b1}}, {128{1'b1}}, 1'b0, 8'h5A, 1'b1,
               {{127{1'b1}}, 1'b0, 127'd0, 1'b1});
    cycle();
    drive_hand({128{1'b1}}, {128{1'b1}}, 1'b1, 8'hA5, 1'b1, 256'd1);
    cycle();
    drive_hand({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b1, 8'h11, 1'b1, {2'b01, 254'd0});
    cycle();
    drive_hand({1'b1, 127'd0}, 128'd1, 1'b1, 8'h22, 1'b1, {{129{1'b1}}, 127'd0});
    cycle();
    drive_hand(128'd0, ~128'd4, 1'b1, 8'h33, 1'b1, 256'd0);
    cycle();
    drive_hand({63'd0, 1'b1, 64'd0}, {63'd0, 1'b1, 64'd0}, 1'b0, 8'h44, 1'b1,
               {127'd0, 1'b1, 128'd0});
    cycle();
    drive_hand(128'd3, 128'd5, 1'b0, 8'h55, 1'b1, 256'd15);
    cycle();
    drain("drain_directed");

    // Back-to-back random stream, mixed modes, out_ready held high.
    for (int i = 0; i < 100; i++) begin
      drive(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 8'(i), 1'b1);
      cycle();
    end
    drain("drain_stream");

    // Backpressure: out_ready low for 5 cycles with in_valid held high.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 8'(8'hC0 + k), 1'b0);
      cycle();
      if (k >= 2) begin
        chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
        chk("bp_out_valid", 256'(out_valid), 256'(1'b1));
        if (k == 2) begin
          hold_p = out_product;
          hold_t = out_tag;
        end else begin
          chk("bp_hold_product", out_product, hold_p);
          chk("bp_hold_tag", 256'(out_tag), 256'(hold_t));
        end
      end
    end
    out_ready = 1'b1;
    drain("drain_backpressure");

    // Reset with operations in flight: none of them may emerge.
    drive(rnd128(), rnd128(), 1'b0, 8'hE1, 1'b0);
    cycle();
    drive(rnd128(), rnd128(), 1'b1, 8'hE2, 1'b0);
    cycle();
    drive(rnd128(), rnd128(), 1'b0, 8'hE3, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_mid_in_ready", 256'(in_ready), 256'(1'b1));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst_mid_no_out", 256'(out_valid), 256'(1'b0));
    end
    drive_hand(128'd7, 128'd6, 1'b0, 8'hF7, 1'b1, 256'd42);
    cycle();
    drain("drain_after_reset");

    // WIDTH=4 exhaustive sweep over both modes.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          in_valid4 = 1'b1;
          in_a4 = 4'(a);
          in_b4 = 4'(b);
          in_signed4 = 1'(m);
          in_tag4 = 1'(a ^ b);
          if (m == 1 && a == 8 && b == 8) drv_exp4 = 8'd64;
          else drv_exp4 = ref_mul4(4'(a), 4'(b), 1'(m));
          cycle();
        end
      end
    end
    drain("drain_small");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
